// File: rtl/bias_add_sat_relu.sv
// bias_add_sat_relu
//   Adds a runtime-loadable per-lane bias to every adder-tree output lane,
//   saturates each lane to DATA_W bits and optionally applies ReLU. The
//   datapath is a 2-stage valid/ready pipeline. A bank of DEPTH bias groups
//   is selected by a group pointer that advances on each accepted in_last
//   and wraps after num_groups groups.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   bias_we/_waddr    write one whole bias group (bias_wdata, lane k at
//   /_wdata           [BIAS_W*(k+1)-1 : BIAS_W*k])
//   num_groups        groups used by the current layer (1..DEPTH)
//   relu_en           clamp negative results to zero (applied in stage 2)
//   start             clears the group pointer and sat_flag
//   in_valid/in_ready input beat handshake; in_data packed as bias_wdata
//   in_last           last beat of the current group
//   out_valid/ready   output beat handshake; out_data packed as in_data
//   group_idx         current group pointer
//   sat_flag          sticky: some lane clipped since start or reset
module bias_add_sat_relu #(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = 18,
    parameter int BIAS_W       = 18,
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           bias_we,
    input  logic [ADDR_W-1:0]              bias_waddr,
    input  logic [N_adder_tree*BIAS_W-1:0] bias_wdata,
    input  logic [ADDR_W:0]                num_groups,
    input  logic                           relu_en,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*DATA_W-1:0] in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]              group_idx,
    output logic                           sat_flag
);

    // Stage-1 sums carry one guard bit so the overflow is visible in stage 2.
    localparam int SW = DATA_W + 1;

    logic [N_adder_tree*BIAS_W-1:0] bank_q [DEPTH];

    logic [ADDR_W-1:0]              grp_q, grp_d;
    logic                           sat_q, sat_d;
    logic                           s1_valid_q;
    logic [N_adder_tree*SW-1:0]     s1_data_q, s1_data_d;
    logic                           out_valid_q;
    logic [N_adder_tree*DATA_W-1:0] out_data_q, out_data_d;

    logic                           adv;
    logic                           accept;
    logic                           clip_any;
    logic [N_adder_tree*BIAS_W-1:0] bias_rd;
    logic [ADDR_W:0]                ng_m1;
    logic [ADDR_W-1:0]              last_grp;
    logic [SW-1:0]                  s2_lane;
    logic [DATA_W-1:0]              s2_res;

    assign adv       = !out_valid_q || out_ready;
    assign accept    = in_valid && adv;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign group_idx = grp_q;
    assign sat_flag  = sat_q;

    // Registered bank read: a same-cycle write is seen only by later beats.
    assign bias_rd = bank_q[grp_q];

    // Illegal num_groups falls back to using the full bank.
    always_comb begin
        ng_m1 = num_groups - 1'b1;
        if (num_groups == '0 || num_groups > (ADDR_W+1)'(DEPTH)) begin
            last_grp = ADDR_W'(DEPTH - 1);
        end else begin
            last_grp = ng_m1[ADDR_W-1:0];
        end
    end

    // Group pointer; start wins over a simultaneous in_last.
    always_comb begin
        grp_d = grp_q;
        if (start) begin
            grp_d = '0;
        end else if (accept && in_last) begin
            grp_d = (grp_q >= last_grp) ? '0 : grp_q + 1'b1;
        end
    end

    // Stage 1: sign-extended add at DATA_W+1 bits.
    always_comb begin
        s1_data_d = '0;
        for (int unsigned k = 0; k < N_adder_tree; k++) begin
            s1_data_d[k*SW +: SW] =
                {in_data[k*DATA_W + DATA_W - 1], in_data[k*DATA_W +: DATA_W]} +
                {{(SW-BIAS_W){bias_rd[k*BIAS_W + BIAS_W - 1]}}, bias_rd[k*BIAS_W +: BIAS_W]};
        end
    end

    // Stage 2: saturate (guard bit differs from sign bit => overflow), then ReLU.
    always_comb begin
        out_data_d = '0;
        clip_any   = 1'b0;
        s2_lane    = '0;
        s2_res     = '0;
        for (int unsigned k = 0; k < N_adder_tree; k++) begin
            s2_lane = s1_data_q[k*SW +: SW];
            if (s2_lane[SW-1] != s2_lane[SW-2]) begin
                clip_any = 1'b1;
                s2_res   = s2_lane[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                s2_res = s2_lane[DATA_W-1:0];
            end
            if (relu_en && s2_res[DATA_W-1]) begin
                s2_res = '0;
            end
            out_data_d[k*DATA_W +: DATA_W] = s2_res;
        end
    end

    // Clip detection is taken before ReLU; start clears with priority.
    always_comb begin
        sat_d = sat_q;
        if (start) begin
            sat_d = 1'b0;
        end else if (adv && s1_valid_q && clip_any) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q       <= '0;
            sat_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            grp_q <= grp_d;
            sat_q <= sat_d;
            if (adv) begin
                s1_valid_q  <= in_valid;
                out_valid_q <= s1_valid_q;
                if (in_valid) begin
                    s1_data_q <= s1_data_d;
                end
                if (s1_valid_q) begin
                    out_data_q <= out_data_d;
                end
            end
        end
    end

    // Bias bank; writes are independent of the pipeline handshake, and
    // addresses beyond DEPTH-1 match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned g = 0; g < DEPTH; g++) begin
                bank_q[g] <= '0;
            end
        end else begin
            for (int unsigned g = 0; g < DEPTH; g++) begin
                if (bias_we && bias_waddr == ADDR_W'(g)) begin
                    bank_q[g] <= bias_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_bias_add_sat_relu.sv
// Self-checking bench for bias_add_sat_relu: a scoreboard predicts every
// output beat at acceptance time; scenario tasks add targeted inline checks.
module tb_bias_add_sat_relu;

    localparam int N     = 16;
    localparam int DW    = 18;
    localparam int BW    = 18;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int MAXV  = (1 << (DW-1)) - 1;
    localparam int MINV  = -(1 << (DW-1));

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            bias_we = 1'b0;
    logic [AW-1:0]   bias_waddr = '0;
    logic [N*BW-1:0] bias_wdata = '0;
    logic [AW:0]     num_groups = 4'd1;
    logic            relu_en = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] in_data = '0;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [N*DW-1:0] out_data;
    logic [AW-1:0]   group_idx;
    logic            sat_flag;

    bias_add_sat_relu #(
        .N_adder_tree(N),
        .DATA_W(DW),
        .BIAS_W(BW),
        .DEPTH(DEPTH),
        .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
        .num_groups(num_groups), .relu_en(relu_en), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .group_idx(group_idx), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_out = 0;
    int timeouts = 0;
    int mbias [DEPTH][N];
    int gptr = 0;
    logic [N*DW-1:0] exp_q [$];
    int din [N];
    int bv [N];

    initial begin
        for (int g = 0; g < DEPTH; g++)
            for (int k = 0; k < N; k++) mbias[g][k] = 0;
    end

    always @(posedge clk) begin
        if (rst_n) assert (num_groups >= 1 && num_groups <= DEPTH)
            else $error("num_groups out of legal range: %0d", num_groups);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic int lane_of(input logic [N*DW-1:0] d, input int k);
        logic [DW-1:0] t;
        t = d[k*DW +: DW];
        return int'($signed(t));
    endfunction

    function automatic logic [N*DW-1:0] pack_din();
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(din[k]);
        return r;
    endfunction

    function automatic logic [N*BW-1:0] pack_bv();
        logic [N*BW-1:0] r;
        for (int k = 0; k < N; k++) r[k*BW +: BW] = BW'(bv[k]);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] model_out(input logic [N*DW-1:0] d, input int g,
                                                  input bit relu);
        logic [N*DW-1:0] r;
        int s;
        for (int k = 0; k < N; k++) begin
            s = lane_of(d, k) + mbias[g][k];
            if (s > MAXV) s = MAXV;
            if (s < MINV) s = MINV;
            if (relu && s < 0) s = 0;
            r[k*DW +: DW] = DW'(s);
        end
        return r;
    endfunction

    // Scoreboard: predict on acceptance, compare on output handshake.
    always @(negedge clk) begin
        logic [N*DW-1:0] expv;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                n_out++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_extra: got beat %h, expected no beat", out_data);
                end else begin
                    expv = exp_q.pop_front();
                    if (out_data !== expv) begin
                        errors++;
                        $display("FAIL scoreboard_data: got %h expected %h", out_data, expv);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_out(in_data, gptr, relu_en));
                if (in_last) gptr = (gptr == num_groups - 1) ? 0 : gptr + 1;
            end
            if (bias_we && bias_waddr < DEPTH)
                for (int k = 0; k < N; k++)
                    mbias[bias_waddr][k] = int'($signed(bias_wdata[k*BW +: BW]));
            if (start) gptr = 0;
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic send(input bit last);
        int i;
        in_valid = 1'b1;
        in_data  = pack_din();
        in_last  = last;
        i = 0;
        @(negedge clk);
        while (!in_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!in_ready) timeouts++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic write_bias(input int g);
        bias_we    = 1'b1;
        bias_waddr = AW'(g);
        bias_wdata = pack_bv();
        @(posedge clk); #1;
        bias_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0) timeouts++;
        @(posedge clk); #1;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeouts++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (group_idx !== '0) begin errors++; $display("FAIL reset_group_idx: got %0d expected 0", group_idx); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic_add();
        int n;
        for (int k = 0; k < N; k++) begin
            bv[k]  = (k == 0) ? -1784 : 37*k - 300;
            din[k] = (k == 0) ? 2000 : 1000*k - 7000;
        end
        write_bias(0);
        send(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        checks++; if (n != 2) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 2", n); end
        checks++; if (lane_of(out_data, 0) != 216) begin errors++; $display("FAIL basic_lane0: got %0d expected 216", lane_of(out_data, 0)); end
        checks++; if (lane_of(out_data, 5) != -2115) begin errors++; $display("FAIL basic_lane5: got %0d expected -2115", lane_of(out_data, 5)); end
        drain();
    endtask

    task automatic test_sat_relu();
        bit ok;
        for (int k = 0; k < N; k++) begin
            bv[k]  = 0;
            din[k] = k;
        end
        bv[3] = 131071; bv[4] = -131072;
        din[3] = 100; din[4] = -5; din[5] = -50;
        write_bias(0);
        pulse_start();
        relu_en = 1'b0;
        send(1'b0);
        wait_out(ok);
        checks++; if (lane_of(out_data, 3) != 131071) begin errors++; $display("FAIL sat_pos: got %0d expected 131071", lane_of(out_data, 3)); end
        checks++; if (lane_of(out_data, 4) != -131072) begin errors++; $display("FAIL sat_neg: got %0d expected -131072", lane_of(out_data, 4)); end
        checks++; if (lane_of(out_data, 5) != -50) begin errors++; $display("FAIL norelu_neg: got %0d expected -50", lane_of(out_data, 5)); end
        drain();
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b expected 1", sat_flag); end
        pulse_start();
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %b expected 0", sat_flag); end
        relu_en = 1'b1;
        din[3] = 0;
        send(1'b0);
        wait_out(ok);
        checks++; if (lane_of(out_data, 4) != 0) begin errors++; $display("FAIL relu_sat_neg: got %0d expected 0", lane_of(out_data, 4)); end
        checks++; if (lane_of(out_data, 5) != 0) begin errors++; $display("FAIL relu_neg: got %0d expected 0", lane_of(out_data, 5)); end
        checks++; if (lane_of(out_data, 3) != 131071) begin errors++; $display("FAIL relu_pos: got %0d expected 131071", lane_of(out_data, 3)); end
        drain();
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL relu_sat_flag: got %b expected 1", sat_flag); end
        relu_en = 1'b0;
    endtask

    task automatic test_group_wrap();
        int exp_g [7] = '{0, 0, 1, 1, 2, 2, 0};
        num_groups = 4'd3;
        pulse_start();
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < N; k++) bv[k] = 10 * (g + 1);
            write_bias(g);
        end
        for (int i = 0; i < 7; i++) begin
            checks++; if (group_idx !== AW'(exp_g[i])) begin errors++; $display("FAIL wrap_group_idx beat %0d: got %0d expected %0d", i, group_idx, exp_g[i]); end
            for (int k = 0; k < N; k++) din[k] = i*7 + k - 20;
            send(i == 1 || i == 3 || i == 5);
        end
        checks++; if (group_idx !== '0) begin errors++; $display("FAIL wrap_group_idx_end: got %0d expected 0", group_idx); end
        drain();
    endtask

    task automatic test_backpressure();
        int n0;
        bit ir_low, stable;
        logic [N*DW-1:0] held;
        num_groups = 4'd1;
        n0 = n_out;
        ir_low = 1'b0;
        stable = 1'b1;
        held = '0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    for (int k = 0; k < N; k++) din[k] = 1000*i + 3*k;
                    send(1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held   = out_data;
                ir_low = out_valid && !in_ready;
                repeat (3) begin
                    @(negedge clk);
                    if (out_data !== held) stable = 1'b0;
                    if (in_ready) ir_low = 1'b0;
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
        checks++; if (!ir_low) begin errors++; $display("FAIL bp_in_ready: got in_ready high during stall expected low"); end
        checks++; if (!stable) begin errors++; $display("FAIL bp_stable: got out_data change during stall expected held %h", held); end
        checks++; if (n_out - n0 != 6) begin errors++; $display("FAIL bp_count: got %0d beats expected 6", n_out - n0); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        num_groups = 4'd3;
        pulse_start();
        for (int k = 0; k < N; k++) din[k] = 50 + k;
        send(1'b1);
        checks++; if (group_idx !== 3'd1) begin errors++; $display("FAIL simul_pre: got %0d expected 1", group_idx); end
        start = 1'b1;
        send(1'b1);
        start = 1'b0;
        checks++; if (group_idx !== 3'd0) begin errors++; $display("FAIL start_vs_last: got %0d expected 0", group_idx); end
        drain();
        for (int k = 0; k < N; k++) bv[k] = 500;
        bias_we    = 1'b1;
        bias_waddr = '0;
        bias_wdata = pack_bv();
        send(1'b0);
        bias_we = 1'b0;
        send(1'b0);
        wait_out(ok);
        checks++; if (lane_of(out_data, 0) != 60) begin errors++; $display("FAIL wr_same_cycle_old: got %0d expected 60", lane_of(out_data, 0)); end
        @(negedge clk);
        checks++; if (!out_valid || lane_of(out_data, 0) != 550) begin errors++; $display("FAIL wr_next_new: got valid=%b lane0=%0d expected valid=1 lane0=550", out_valid, lane_of(out_data, 0)); end
        drain();
    endtask

    task automatic test_async_reset();
        bit ok;
        num_groups = 4'd3;
        pulse_start();
        for (int k = 0; k < N; k++) din[k] = k;
        din[0] = 131000;
        send(1'b1);
        din[0] = 5;
        repeat (3) send(1'b0);
        in_valid = 1'b1;
        in_data  = pack_din();
        #2;
        checks++; if (sat_flag !== 1'b1 || group_idx !== 3'd1) begin errors++; $display("FAIL prereset_state: got sat=%b grp=%0d expected sat=1 grp=1", sat_flag, group_idx); end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        gptr = 0;
        for (int g = 0; g < DEPTH; g++)
            for (int k = 0; k < N; k++) mbias[g][k] = 0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
        checks++; if (group_idx !== '0) begin errors++; $display("FAIL areset_group_idx: got %0d expected 0", group_idx); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL areset_sat_flag: got %b expected 0", sat_flag); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL areset_out_data: got %h expected 0", out_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
        for (int k = 0; k < N; k++) din[k] = 11*k - 50;
        din[0] = 777;
        send(1'b0);
        wait_out(ok);
        checks++; if (lane_of(out_data, 0) != 777) begin errors++; $display("FAIL areset_passthru: got %0d expected 777", lane_of(out_data, 0)); end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_sat_relu();
        test_group_wrap();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
        checks++; if (timeouts != 0) begin errors++; $display("FAIL wait_bounds: got %0d timeouts expected 0", timeouts); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
